// File: rtl/spi_reg_writer.sv
// SPI mode-0 master that emits one 16-bit {wr, addr, wdata} register-write frame per start.
// It captures the last 8 sdo samples of each frame into rdata.
module spi_reg_writer #(
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int FRAME_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       sdo,
    output logic       sclk,
    output logic       cs,
    output logic       sdi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    localparam int PMAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int PMAX1 = (CS_HOLD > FRAME_GAP) ? CS_HOLD : FRAME_GAP;
    localparam int PMAX  = (PMAX0 > PMAX1) ? PMAX0 : PMAX1;
    localparam int PW    = $clog2(PMAX + 1);

    if (CLK_DIV < 4 || CS_SETUP < 2 || CS_HOLD < 2 || FRAME_GAP < 4) begin : g_param_check
        $error("spi_reg_writer: parameter below its legal range");
    end

    typedef enum logic [2:0] {
        IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP, DONE
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [15:0]   tx_sr, tx_sr_nx;
    logic [7:0]    rx_sr, rx_sr_nx;
    logic          sclk_nx, cs_nx, sdi_nx, busy_nx, done_nx;
    logic [7:0]    rdata_nx;
    logic          phase_end;
    logic          last_bit;

    assign last_bit = (bit_cnt == 4'd15);

    // SETUP compares against CS_SETUP (not -1) so the first rise lands CS_SETUP+1 cycles after accept
    always_comb begin
        phase_end = 1'b0;
        case (state)
            SETUP:          phase_end = (phase == PW'(CS_SETUP));
            SCK_HI, SCK_LO: phase_end = (phase == PW'(CLK_DIV - 1));
            HOLD:           phase_end = (phase == PW'(CS_HOLD - 1));
            GAP:            phase_end = (phase == PW'(FRAME_GAP - 1));
            default:        phase_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            sdi     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            bit_cnt <= bit_cnt_nx;
            tx_sr   <= tx_sr_nx;
            rx_sr   <= rx_sr_nx;
            sclk    <= sclk_nx;
            cs      <= cs_nx;
            sdi     <= sdi_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            rdata   <= rdata_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        bit_cnt_nx = bit_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                    phase_nx = '0;
                end
            end
            SETUP, SCK_LO, HOLD, GAP: begin
                if (phase_end) begin
                    phase_nx = '0;
                    case (state)
                        SETUP:   state_nx = SCK_HI;
                        SCK_LO:  state_nx = SCK_HI;
                        HOLD:    state_nx = GAP;
                        default: state_nx = DONE;
                    endcase
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            SCK_HI: begin
                if (phase_end) begin
                    phase_nx   = '0;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    state_nx   = last_bit ? HOLD : SCK_LO;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // registered outputs: these are the values presented after the coming edge
    always_comb begin
        sclk_nx  = sclk;
        cs_nx    = cs;
        sdi_nx   = sdi;
        busy_nx  = busy;
        done_nx  = 1'b0;
        rdata_nx = rdata;
        tx_sr_nx = tx_sr;
        rx_sr_nx = rx_sr;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_sr_nx = {wr, addr, wdata};
                    cs_nx    = 1'b0;
                    sdi_nx   = wr;
                    busy_nx  = 1'b1;
                end
            end
            SETUP, SCK_LO: begin
                if (phase_end) begin
                    sclk_nx  = 1'b1;
                    rx_sr_nx = {rx_sr[6:0], sdo};
                end
            end
            SCK_HI: begin
                if (phase_end) begin
                    sclk_nx = 1'b0;
                    if (!last_bit) begin
                        tx_sr_nx = {tx_sr[14:0], 1'b0};
                        sdi_nx   = tx_sr[14];
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    cs_nx  = 1'b1;
                    sdi_nx = 1'b0;
                end
            end
            GAP: begin
                if (phase_end) begin
                    done_nx  = 1'b1;
                    rdata_nx = rx_sr;
                end
            end
            DONE:    busy_nx = 1'b0;
            default: busy_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: a default instance and a CLK_DIV=8 instance, each with a
// register-file peripheral model, sdo driver and a done-triggered scoreboard monitor.
module tb_spi_reg_writer;

    typedef struct packed {
        logic        id;
        logic [15:0] frame;
        logic [7:0]  rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [2] = '{1'b0, 1'b0};
    logic       wr = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       sdo [2];
    logic       sclk_w [2];
    logic       cs_w [2];
    logic       sdi_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [7:0] rdata_w [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q [$];

    logic [15:0] sdo_pat [2] = '{16'h0000, 16'h0000};
    int          rise_cnt [2] = '{0, 0};
    int          t_fall [2] = '{0, 0};
    int          t_edge [2] = '{0, 0};
    int          t_csrise [2] = '{0, 0};
    int          first_off [2] = '{0, 0};
    int          last_cnt [2] = '{0, 0};
    logic [15:0] shreg [2] = '{16'h0, 16'h0};
    logic [15:0] last_frame [2] = '{16'h0, 16'h0};
    bit          seq_bad [2] = '{1'b0, 1'b0};
    bit          have_rise [2] = '{1'b0, 1'b0};
    bit          dn_pend [2] = '{1'b0, 1'b0};
    logic        cs_p [2] = '{1'b1, 1'b1};
    logic        sclk_p [2] = '{1'b0, 1'b0};
    logic        done_p [2] = '{1'b0, 1'b0};
    logic        sdi_hi [2] = '{1'b0, 1'b0};
    logic [7:0]  regs [2][5] = '{default: '0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [39:0] regs_of(input int g);
        return {regs[g][4], regs[g][3], regs[g][2], regs[g][1], regs[g][0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : 8;
        localparam int LAT = 1 + 4 + 31 * DIV + 4 + 4;

        spi_reg_writer #(.CLK_DIV(DIV)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start[g]),
            .wr    (wr),
            .addr  (addr),
            .wdata (wdata),
            .sdo   (sdo[g]),
            .sclk  (sclk_w[g]),
            .cs    (cs_w[g]),
            .sdi   (sdi_w[g]),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .rdata (rdata_w[g])
        );

        always @(negedge clk) begin
            exp_t e;
            if (dn_pend[g]) begin
                chk($sformatf("done_pulse_end%0d", g), {done_w[g], busy_w[g]}, 2'b00);
                dn_pend[g] = 1'b0;
            end
            if (cs_p[g] && !cs_w[g]) begin
                if (have_rise[g])
                    chk($sformatf("cs_gap_ok%0d", g), (cyc - t_csrise[g]) >= 5, 1'b1);
                rise_cnt[g] = 0;
                shreg[g]    = '0;
                seq_bad[g]  = 1'b0;
                t_fall[g]   = cyc;
            end
            if (sclk_p[g] && sclk_w[g] && sdi_w[g] !== sdi_hi[g])
                seq_bad[g] = 1'b1;
            if (!sclk_p[g] && sclk_w[g]) begin
                if (rise_cnt[g] == 0) first_off[g] = cyc - t_fall[g];
                else if (cyc - t_edge[g] != DIV) seq_bad[g] = 1'b1;
                t_edge[g]   = cyc;
                sdi_hi[g]   = sdi_w[g];
                shreg[g]    = {shreg[g][14:0], sdi_w[g]};
                rise_cnt[g] = rise_cnt[g] + 1;
            end
            if (sclk_p[g] && !sclk_w[g]) begin
                if (cyc - t_edge[g] != DIV) seq_bad[g] = 1'b1;
                t_edge[g] = cyc;
            end
            if (!cs_p[g] && cs_w[g]) begin
                t_csrise[g]   = cyc;
                have_rise[g]  = 1'b1;
                last_frame[g] = shreg[g];
                last_cnt[g]   = rise_cnt[g];
                if (rise_cnt[g] == 16 && shreg[g][15] && shreg[g][14:8] < 7'd5)
                    regs[g][shreg[g][10:8]] = shreg[g][7:0];
            end
            if (done_w[g] && !done_p[g]) begin
                dn_pend[g] = 1'b1;
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_done%0d", g), 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_dut_id", g, e.id);
                    chk("frame_bits", last_frame[g], e.frame);
                    chk("rise_count", last_cnt[g], 16);
                    chk("rdata", rdata_w[g], e.rd);
                    chk("done_latency", cyc - t_fall[g], LAT);
                    chk("first_rise_offset", first_off[g], 5);
                    chk("sclk_sdi_timing_bad", seq_bad[g], 1'b0);
                end
            end
            sdo[g]    = (rise_cnt[g] < 16) ? sdo_pat[g][15 - rise_cnt[g]] : 1'b0;
            cs_p[g]   = cs_w[g];
            sclk_p[g] = sclk_w[g];
            done_p[g] = done_w[g];
        end
    end

    task automatic expect_frame(input int g, input logic [15:0] f, input logic [7:0] rd);
        exp_t e;
        e.id = g[0];
        e.frame = f;
        e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input int g, input logic val);
        int i = 0;
        while (busy_w[g] !== val && i < 2000) begin
            @(negedge clk);
            i++;
        end
        if (busy_w[g] !== val) chk("busy_wait_timeout", busy_w[g], val);
    endtask

    task automatic wait_done(input int g);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = done_w[g];
        end
        if (!seen) chk("done_wait_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_rise(input int g, input int n);
        int i = 0;
        while (!(rise_cnt[g] == n && sclk_w[g]) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        if (!(rise_cnt[g] == n && sclk_w[g])) chk("rise_wait_timeout", rise_cnt[g], n);
    endtask

    task automatic issue(input int g, input logic w, input logic [6:0] a, input logic [7:0] d);
        wait_busy(g, 1'b0);
        wr = w;
        addr = a;
        wdata = d;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk($sformatf("reset_outputs%0d", g),
                {sclk_w[g], cs_w[g], sdi_w[g], busy_w[g], done_w[g], rdata_w[g]},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk($sformatf("post_reset_outputs%0d", g),
                {sclk_w[g], cs_w[g], sdi_w[g], busy_w[g], done_w[g], rdata_w[g]},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        // 2: single write frame 0x82A5; sdo makes the last 8 samples 0xC3
        sdo_pat[0] = 16'hFFC3;
        expect_frame(0, 16'h82A5, 8'hC3);
        issue(0, 1'b1, 7'h02, 8'hA5);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("regs_after_t2", regs_of(0), 40'h00_00_A5_00_00);

        // 3: start held high, two back-to-back frames
        sdo_pat[0] = 16'h0000;
        wr = 1'b1;
        addr = 7'h00;
        wdata = 8'h11;
        start[0] = 1'b1;
        expect_frame(0, 16'h8011, 8'h00);
        wait_busy(0, 1'b1);
        addr = 7'h04;
        wdata = 8'h22;
        expect_frame(0, 16'h8422, 8'h00);
        wait_done(0);
        wait_busy(0, 1'b0);
        wait_busy(0, 1'b1);
        start[0] = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("regs_after_t3", regs_of(0), 40'h22_00_A5_00_11);

        // 4: second start mid-frame is ignored
        expect_frame(0, 16'h815A, 8'h00);
        issue(0, 1'b1, 7'h01, 8'h5A);
        wait_rise(0, 6);
        addr = 7'h03;
        wdata = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        repeat (20) @(negedge clk);
        chk("t4_idle_after_done", busy_w[0], 1'b0);
        chk("regs_after_t4", regs_of(0), 40'h22_00_A5_5A_11);

        // 5: reset during bit 7 high phase, then a full frame
        issue(0, 1'b1, 7'h03, 8'h77);
        wait_rise(0, 7);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs_sclk_busy", {cs_w[0], sclk_w[0], busy_w[0]}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("regs_after_abort", regs_of(0), 40'h22_00_A5_5A_11);
        chk("rdata_after_abort", rdata_w[0], 8'h00);
        expect_frame(0, 16'h8133, 8'h00);
        issue(0, 1'b1, 7'h01, 8'h33);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("regs_after_t5", regs_of(0), 40'h22_00_A5_33_11);

        // 6: CLK_DIV=8 instance, read-style frame with sdo pattern ending 0x3C
        sdo_pat[1] = 16'hA53C;
        expect_frame(1, 16'h0299, 8'h3C);
        issue(1, 1'b0, 7'h02, 8'h99);
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("regs_dut8_wr0", regs_of(1), 40'h0);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/spi_reg_writer.md
Name: spi_reg_writer

Overview:
SPI controller that generates the 16-bit register-write frames consumed by the chip's SPI register-file peripheral: it drives sclk, cs and sdi, and samples sdo. It is used by on-chip test/bring-up logic and FPGA harnesses to program the five control registers. Frame format is MSB-first {wr, addr[6:0], wdata[7:0]}, SPI mode 0. Frame timing is slow enough for a peripheral that samples sclk/cs/sdi through two-flop synchronisers on the same system clock.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥4.
CS_SETUP, 4, clk cycles with cs low and bit 15 driven before the first sclk rise; legal range ≥2.
CS_HOLD, 4, clk cycles with cs low and sclk low after the 16th sclk fall; legal range ≥2.
FRAME_GAP, 4, clk cycles cs is held high after a frame before done; legal range ≥4.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a frame; accepted only when busy=0.
wr  input  1  frame bit 15 (1 = write command).
addr  input  7  frame bits 14:8.
wdata  input  8  frame bits 7:0.
sdo  input  1  serial data from peripheral, sampled on sclk rise.
sclk  output  1  SPI clock, idle low.
cs  output  1  chip select, active low, idle high.
sdi  output  1  serial data to peripheral.
busy  output  1  frame in progress.
done  output  1  one-cycle pulse at end of frame.
rdata  output  8  last 8 bits sampled from sdo in the most recent frame.

Behaviour:
- Reset (async, immediate): sclk=0, cs=1, sdi=0, busy=0, done=0, rdata=0, state=IDLE, all counters 0.
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP, DONE.
- IDLE: if start=1 at posedge, latch shift register {wr,addr,wdata}; next cycle cs=0, sdi=bit15, busy=1, enter SETUP. Otherwise outputs stay at idle values.
- SETUP: lasts CS_SETUP cycles, then sclk=1, enter SCK_HI.
- SCK_HI: lasts CLK_DIV cycles. sdi stays stable for the whole phase. sdo is sampled into an 8-bit shift register on the cycle sclk rises. Then sclk=0, bit counter increments, enter SCK_LO.
- SCK_LO: sdi is updated to the next bit in the same cycle sclk falls, held for CLK_DIV cycles, then sclk=1 and back to SCK_HI. After the 16th fall, go to HOLD instead; the SCK_LO phase is skipped and sdi is held at bit 0.
- HOLD: CS_HOLD cycles with cs=0 and sclk=0, then cs=1, sdi=0, enter GAP.
- GAP: FRAME_GAP cycles, then DONE.
- DONE: done=1 for one cycle, busy still 1, rdata updated from the sdo shift register (last 8 samples, MSB first). Next cycle: IDLE, busy=0.
- Frame shape: exactly 16 sclk rising edges per frame. First rise occurs CS_SETUP+1 cycles after start is accepted.
- Latency: done asserts exactly 1+CS_SETUP+32·CLK_DIV−CLK_DIV+CS_HOLD+FRAME_GAP cycles after the start-accept edge; 137 with defaults.
- start while busy=1, including the DONE cycle, is ignored; there is no queuing. Changes to wr/addr/wdata after accept do not affect the frame in flight.
- start held high continuously produces back-to-back frames, each with cs high for ≥FRAME_GAP+1 cycles between them.
- Counters: bit counter 4 bits (0..15, wraps only on frame end); phase counter sized for max(CLK_DIV,CS_SETUP,CS_HOLD,FRAME_GAP).
- Reset mid-frame: cs returns high and sclk low immediately. The partial frame is never completed and done does not pulse; a peripheral discards a frame with fewer than 16 bits.
- Simulation assertion: parameters below their legal range are flagged as an error.

Test Plan:
1. Hold rst=1, toggle clk -> sclk=0, cs=1, sdi=0, busy=0, done=0, rdata=0x00; release rst -> all outputs unchanged.
2. Defaults, start pulse with wr=1, addr=0x02, wdata=0xA5 -> sdi at each of 16 sclk rises reads 0x82A5 MSB-first; sclk high and low phases are 4 clk each; done at cycle 137. With the register peripheral attached, its third register becomes 0xA5 and the others stay 0.
3. start held high with frames 0x80_11 then 0x84_22 -> two complete frames; cs high ≥5 cycles between them; peripheral registers 0=0x11 and 4=0x22.
4. Pulse start; at bit 6 pulse start again and change addr/wdata -> second start ignored; sdi sequence remains the first frame; only one done pulse.
5. Assert rst during SCK_HI of bit 7 -> cs=1 and sclk=0 in the same cycle, no done pulse, peripheral registers unchanged. A following full frame is accepted correctly.
6. CLK_DIV=8 override; model drives sdo so the last 8 sampled bits are 0x3C -> sclk half-period is 8 clk; rdata=0x3C valid in the done cycle; wr=0 frame produces no register change in the peripheral.
